datamem_responder: RTL and testbench
====================================

DATAMEM_RESPONDER -- requirements
Module: datamem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2, is the number of idle cycles between request acceptance and response (legal range 0..15).
REQ-002 Parameter DEPTH_LOG2, default 10, gives the word-storage depth of 2^DEPTH_LOG2 32-bit words, indexed by addr[DEPTH_LOG2+1:2].
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port resetn, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req, input, 1 bit: request strobe from the CPU-side initiator.
REQ-006 Port we, input, 1 bit: 1 = write, 0 = read; sampled with req.
REQ-007 Port addr, input, 32 bits: byte address; sampled with req.
REQ-008 Port wdata, input, 32 bits: write data; sampled with req.
REQ-009 Port be, input, 4 bits: byte enables for writes, where be[i] covers wdata[8i+7:8i]; sampled with req.
REQ-010 Port rdata, output, 32 bits: read data, valid while ack=1.
REQ-011 Port ack, output, 1 bit: one-cycle response pulse.
REQ-012 Port err, output, 1 bit: error flag, valid while ack=1.
REQ-013 Port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT, and RESP.
REQ-015 In IDLE with req=1, the block SHALL capture we, addr, wdata, and be into internal registers and load the wait counter with WAIT_STATES.
- Next state is WAIT if WAIT_STATES>0, otherwise RESP.
REQ-016 In WAIT, the counter SHALL decrement once per cycle, and the FSM SHALL move to RESP in the cycle after the counter reaches 1.
- Result: exactly WAIT_STATES cycles are spent in WAIT.
REQ-017 In RESP, ack SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-018 Latency from the req-sampling edge to ack high SHALL be WAIT_STATES+1 cycles.
- Minimum request-to-request spacing is WAIT_STATES+2 cycles.
REQ-019 req asserted while in WAIT or RESP SHALL be ignored: no capture and no queuing.
- The initiator re-asserts req, or holds it, until acceptance in IDLE.
REQ-020 A captured address SHALL be out of range when any bit of addr[31:DEPTH_LOG2+2] is nonzero or addr[1:0]!=0.
- An out-of-range access SHALL respond with err=1, rdata=0, and no storage modification.
REQ-021 Writes SHALL commit to storage on the clock edge that ends the RESP cycle, updating only the bytes whose be bit is 1.
- be=4'b0000 is a legal no-op write and SHALL still ack with err=0.
REQ-022 Reads SHALL return the full 32-bit word and ignore be.
- A read SHALL return the value of every write whose RESP ended before that read was captured.
REQ-023 rdata and err SHALL hold their last response values between responses.
- rdata SHALL be 0 after a write response.
REQ-024 The storage array SHALL NOT be cleared by reset; its contents are undefined until written.

Reset
REQ-025 When resetn=1 at a rising edge, the block SHALL enter IDLE with ack=0, err=0, busy=0, rdata=32'h0, and the wait counter at 0.
REQ-026 Reset SHALL take priority over every other event in the same cycle.
- A write whose RESP cycle coincides with reset SHALL NOT commit.
- A req in the same cycle as reset SHALL NOT be accepted.
REQ-027 After resetn returns to 0, a req in the first non-reset cycle SHALL be accepted.

Verification
REQ-028 Baseline write/read (WAIT_STATES=2): write addr=0x10, wdata=0xDEADBEEF, be=4'hF, then read 0x10.
- ack SHALL occur 3 cycles after each req edge.
- The read SHALL return rdata=0xDEADBEEF with err=0.
REQ-029 Partial write: write 0x11223344 to 0x20 with be=4'hF, then write 0xAABBCCDD with be=4'b0101, then read 0x20.
- The read SHALL return 0x11BB33DD.
REQ-030 Out-of-range and misaligned accesses: read 0x00001000, then write 0x22.
- Both SHALL ack with err=1.
- A subsequent read of 0x20 SHALL be unchanged.
REQ-031 Busy rejection: req pulsed in each WAIT cycle after an accepted read.
- The block SHALL produce exactly one ack.
- busy SHALL be 1 for exactly WAIT_STATES+1 cycles.
REQ-032 Reset mid-operation: resetn asserted in the RESP cycle of a write of 0xCAFEF00D to 0x30 (previously 0).
- ack, err, and busy SHALL be 0 on the next cycle.
- A later read of 0x30 SHALL return 0.
REQ-033 Zero-latency build (WAIT_STATES=0): back-to-back reqs held high continuously.
- ack SHALL occur every 2nd cycle, each 1 cycle after its acceptance edge.

Source files
------------

// File: rtl/datamem_responder_if.sv
// Purpose: request/response bundle between a CPU-side initiator and the data-memory responder.
// Latency: none, wires only.
// Backpressure: none in the bundle; the responder takes req only when not busy.
interface datamem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    // Initiator side: drives the request, observes the response
    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err, busy
    );

    // Responder side: observes the request, drives the response
    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/datamem_responder.sv
// Purpose: word-addressed data memory answering one CPU request at a time, with byte-enabled writes.
// Latency: ack is high WAIT_STATES+1 cycles after the accepting edge; a new request is taken at the earliest WAIT_STATES+2 cycles later.
// Backpressure: req is accepted only in IDLE; requests seen while busy are dropped, and the initiator must hold or re-assert them.
module datamem_responder #(
    parameter int WAIT_STATES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic               clock,
    input  logic               resetn,
    datamem_responder_if.slave bus
);
    localparam int         DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Out of range when any bit above the storage window is set, or the address is not word aligned
    function automatic logic addr_oor(input logic [31:0] a);
        return ((a >> (DEPTH_LOG2 + 2)) != 32'd0) || (a[1:0] != 2'b00);
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_accept;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic        r_ack;
    logic        r_err;
    logic [31:0] r_rdata;

    logic [31:0] r_mem [DEPTH];

    logic        w_enter_resp;
    logic        w_lk_we;
    logic [31:0] w_lk_addr;
    logic        w_lk_oor;
    logic [31:0] w_lk_word;
    logic        w_reg_oor;
    logic        w_commit;

    // Next-state and counter logic; requests outside IDLE fall through untouched
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = WAIT_LOAD;
                    w_state_nxt = (WAIT_LOAD != 4'd0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                // A zero count here can only come from corruption; leave rather than wrap
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, wait counter and request capture; reset wins over acceptance
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
                r_be    <= bus.be;
            end
        end
    end

    // With no wait states the response is formed on the accepting edge, so look at the live request then
    assign w_lk_we      = (r_state == IDLE) ? bus.we   : r_we;
    assign w_lk_addr    = (r_state == IDLE) ? bus.addr : r_addr;
    assign w_lk_oor     = addr_oor(w_lk_addr);
    assign w_lk_word    = r_mem[w_lk_addr[DEPTH_LOG2+1:2]];
    assign w_enter_resp = (w_state_nxt == RESP);

    // Response registers: loaded on the edge entering RESP, held until the next response
    always_ff @(posedge clock) begin
        if (resetn) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack <= w_enter_resp;
            if (w_enter_resp) begin
                r_err   <= w_lk_oor;
                r_rdata <= (w_lk_we || w_lk_oor) ? 32'd0 : w_lk_word;
            end
        end
    end

    // A write lands on the edge that ends RESP, unless reset is asserted on that same edge
    assign w_reg_oor = addr_oor(r_addr);
    assign w_commit  = !resetn && (r_state == RESP) && r_we && !w_reg_oor;

    // Byte-enabled storage update; the array itself is never cleared
    always_ff @(posedge clock) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_addr[DEPTH_LOG2+1:2]][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.busy  = (r_state != IDLE);

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: directed scenarios plus random traffic against a word-array model.
// Drives on the falling edge and samples on the falling edge.
// Two instances: WAIT_STATES=2 for most scenarios, WAIT_STATES=0 for the back-to-back case.
module tb_datamem_responder;
    localparam int WS = 2;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    datamem_responder_if bus0 ();
    datamem_responder_if bus1 ();

    datamem_responder #(.WAIT_STATES(WS), .DEPTH_LOG2(10)) u_dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus0)
    );

    datamem_responder #(.WAIT_STATES(0), .DEPTH_LOG2(10)) u_dut0 (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference storage for the random section: 16 words starting at byte 0x200
    logic [31:0] model [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request on bus0 from IDLE; returns response and cycles from the accepting edge to ack
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] rd, output logic er, output int lat);
        bit got;
        got = 1'b0;
        @(negedge clock);
        bus0.req   = 1'b1;
        bus0.we    = w;
        bus0.addr  = a;
        bus0.wdata = d;
        bus0.be    = b;
        @(posedge clock);
        #1 bus0.req = 1'b0;
        lat = 0;
        rd  = 'x;
        er  = 1'bx;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (bus0.ack === 1'b1) begin
                got = 1'b1;
                rd  = bus0.rdata;
                er  = bus0.err;
            end
        end
        if (!got) lat = -1;
    endtask

    task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(w, a, d, b, rd, er, lat);
        check({tag, "_lat"}, lat, WS + 1);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acks;
        int          busyc;
        bit          got_ack;
        int          k;
        int          kind;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] a;

        resetn     = 1'b1;
        bus0.req   = 1'b0;
        bus0.we    = 1'b0;
        bus0.addr  = 32'd0;
        bus0.wdata = 32'd0;
        bus0.be    = 4'd0;
        bus1.req   = 1'b0;
        bus1.we    = 1'b0;
        bus1.addr  = 32'd0;
        bus1.wdata = 32'd0;
        bus1.be    = 4'd0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ack", bus0.ack, 0);
        check("rst_err", bus0.err, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_rdata", bus0.rdata, 32'h0);
        check("rst0_busy", bus1.busy, 0);

        // Release reset so that the first request lands in the first non-reset cycle
        @(posedge clock);
        #1 resetn = 1'b0;
        access("base_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        access("base_rd", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Partial writes and the be=0 no-op
        access("part_wr1", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        access("part_wr2", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        access("part_rd", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);
        access("be0_wr", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        access("be0_rd", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        // Out-of-range and misaligned accesses, then confirm nothing moved
        access("oor_rd", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1);
        access("mis_wr", 1'b1, 32'h22, 32'h55555555, 4'hF, 32'h0, 1'b1);
        repeat (3) @(negedge clock);
        check("hold_err", bus0.err, 1);
        check("hold_ack", bus0.ack, 0);
        access("oor_after_rd", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        repeat (3) @(negedge clock);
        check("hold_rdata", bus0.rdata, 32'h11BB33DD);
        check("hold_err0", bus0.err, 0);

        // Requests during WAIT must be dropped
        @(negedge clock);
        bus0.req  = 1'b1;
        bus0.we   = 1'b0;
        bus0.addr = 32'h10;
        bus0.be   = 4'h0;
        @(posedge clock);
        acks  = 0;
        busyc = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (bus0.ack === 1'b1) begin
                acks++;
                check("busy_rdata", bus0.rdata, 32'hDEADBEEF);
            end
            if (bus0.busy === 1'b1) busyc++;
            bus0.req = (c <= WS);
        end
        bus0.req = 1'b0;
        check("busy_acks", acks, 1);
        check("busy_cycles", busyc, WS + 1);

        // Reset landing on the RESP cycle of a write must cancel the commit
        access("r30_clear", 1'b1, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0);
        @(negedge clock);
        bus0.req   = 1'b1;
        bus0.we    = 1'b1;
        bus0.addr  = 32'h30;
        bus0.wdata = 32'hCAFEF00D;
        bus0.be    = 4'hF;
        @(posedge clock);
        #1 bus0.req = 1'b0;
        got_ack = 1'b0;
        for (int i = 0; i < 20 && !got_ack; i++) begin
            @(negedge clock);
            if (bus0.ack === 1'b1) begin
                got_ack = 1'b1;
                resetn  = 1'b1;
            end
        end
        check("rstmid_ack_seen", {31'd0, got_ack}, 1);
        @(negedge clock);
        check("rstmid_ack", bus0.ack, 0);
        check("rstmid_err", bus0.err, 0);
        check("rstmid_busy", bus0.busy, 0);
        @(posedge clock);
        #1 resetn = 1'b0;
        access("rstmid_rd", 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);

        // A request coinciding with reset is not accepted
        @(negedge clock);
        resetn    = 1'b1;
        bus0.req  = 1'b1;
        bus0.we   = 1'b0;
        bus0.addr = 32'h10;
        @(negedge clock);
        check("rstreq_busy", bus0.busy, 0);
        check("rstreq_ack", bus0.ack, 0);
        bus0.req = 1'b0;
        resetn   = 1'b0;

        // Random traffic against the word-array model
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            access("rnd_init", 1'b1, 32'h200 + i * 4, model[i], 4'hF, 32'h0, 1'b0);
        end
        for (int n = 0; n < 60; n++) begin
            k    = $urandom_range(0, 15);
            kind = $urandom_range(0, 9);
            d    = $urandom;
            b    = 4'($urandom);
            a    = 32'h200 + k * 4;
            if (kind < 4) begin
                access("rnd_rd", 1'b0, a, d, b, model[k], 1'b0);
            end else if (kind < 8) begin
                access("rnd_wr", 1'b1, a, d, b, 32'h0, 1'b0);
                for (int j = 0; j < 4; j++) begin
                    if (b[j]) model[k][8*j +: 8] = d[8*j +: 8];
                end
            end else begin
                if (kind == 8) a = a + 32'($urandom_range(1, 3));
                else           a = a | (32'h1000 << $urandom_range(0, 19));
                access("rnd_oor", 1'($urandom_range(0, 1)), a, d, b, 32'h0, 1'b1);
            end
        end
        for (int i = 0; i < 16; i++) begin
            access("rnd_final", 1'b0, 32'h200 + i * 4, 32'h0, 4'h0, model[i], 1'b0);
        end

        // Zero-wait instance with req held high: ack on every second cycle after the first acceptance
        @(negedge clock);
        bus1.req   = 1'b1;
        bus1.we    = 1'b1;
        bus1.addr  = 32'h40;
        bus1.wdata = 32'h12345678;
        bus1.be    = 4'hF;
        @(posedge clock);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            check("w0_ack", bus1.ack, (c % 2 == 1) ? 32'd1 : 32'd0);
            check("w0_busy", bus1.busy, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c % 2 == 1) check("w0_err", bus1.err, 0);
        end
        bus1.req = 1'b0;
        repeat (2) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
